// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single MMU port between instruction fetch and load/store.
// Each access is held on the bus for 1+WAIT_CYCLES cycles. It is followed by a
// quiet cycle in which the winning port's ready pulses and read data is latched.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic        data_byte,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        mmu_if_read,
  output logic        mmu_if_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_input_data,
  output logic        mmu_bytemode,
  input  logic [31:0] mmu_output_data,
  output logic        stall
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mem_bus_arbiter: WAIT_CYCLES must be within 0..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;  // 0 = inst, 1 = data
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        byte_q, byte_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_ready_q, inst_ready_d;
  logic        data_ready_q, data_ready_d;
  logic        inst_elig, data_elig;

  // State register; every output is a flop so the MMU sees glitch-free strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      byte_q       <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_q       <= byte_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
    end
  end

  // Next-state: grant in IDLE, count down while busy, finish with a ready pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_d       = byte_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    // A port in its ready cycle still shows its old request; it is already served.
    inst_elig    = inst_req & ~inst_ready_q;
    data_elig    = data_req & ~data_ready_q;

    case (state_q)
      IDLE: begin
        if (data_elig && (!inst_elig || !last_grant_q)) begin
          state_d      = BUSY_D;
          last_grant_d = 1'b1;
          cnt_d        = CNT_INIT;
          rd_d         = ~data_we;
          wr_d         = data_we;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          byte_d       = data_byte;
        end else if (inst_elig) begin
          state_d      = BUSY_I;
          last_grant_d = 1'b0;
          cnt_d        = CNT_INIT;
          rd_d         = 1'b1;
          wr_d         = 1'b0;
          addr_d       = inst_addr;
          wdata_d      = 32'd0;
          byte_d       = 1'b0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = 32'd0;
          wdata_d = 32'd0;
          byte_d  = 1'b0;
          if (state_q == BUSY_I) begin
            inst_ready_d = 1'b1;
            inst_rdata_d = mmu_output_data;
          end else begin
            data_ready_d = 1'b1;
            // Stores leave the last load result visible.
            if (!wr_q) data_rdata_d = mmu_output_data;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = 32'd0;
        wdata_d = 32'd0;
        byte_d  = 1'b0;
      end
    endcase
  end

  assign mmu_if_read    = rd_q;
  assign mmu_if_write   = wr_q;
  assign mmu_addr       = addr_q;
  assign mmu_input_data = wdata_q;
  assign mmu_bytemode   = byte_q;
  assign inst_rdata     = inst_rdata_q;
  assign data_rdata     = data_rdata_q;
  assign inst_ready     = inst_ready_q;
  assign data_ready     = data_ready_q;
  assign stall          = (inst_req & ~inst_ready_q) | (data_req & ~data_ready_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (WAIT_CYCLES 0, 2, 3) share one
// stimulus set, with `sel` routing requests and outputs to one of them.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        inst_req, data_req, data_we, data_byte;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [31:0] mmu_output_data;

  logic        inst_req_w [3];
  logic        data_req_w [3];
  logic [31:0] inst_rdata_w [3];
  logic [31:0] data_rdata_w [3];
  logic        inst_ready_w [3];
  logic        data_ready_w [3];
  logic        rd_w [3];
  logic        wr_w [3];
  logic [31:0] addr_w [3];
  logic [31:0] wdata_w [3];
  logic        byte_w [3];
  logic        stall_w [3];

  logic [31:0] inst_rdata_s, data_rdata_s, addr_s, wdata_s;
  logic        inst_ready_s, data_ready_s, rd_s, wr_s, byte_s, stall_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          start;
    int          n;
  } bus_t;

  typedef struct {
    bit          port;  // 0 = inst, 1 = data
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];
  int   bidx = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    assign inst_req_w[g] = inst_req & (sel == 2'(g));
    assign data_req_w[g] = data_req & (sel == 2'(g));
    mem_bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .inst_req        (inst_req_w[g]),
      .inst_addr       (inst_addr),
      .inst_rdata      (inst_rdata_w[g]),
      .inst_ready      (inst_ready_w[g]),
      .data_req        (data_req_w[g]),
      .data_we         (data_we),
      .data_byte       (data_byte),
      .data_addr       (data_addr),
      .data_wdata      (data_wdata),
      .data_rdata      (data_rdata_w[g]),
      .data_ready      (data_ready_w[g]),
      .mmu_if_read     (rd_w[g]),
      .mmu_if_write    (wr_w[g]),
      .mmu_addr        (addr_w[g]),
      .mmu_input_data  (wdata_w[g]),
      .mmu_bytemode    (byte_w[g]),
      .mmu_output_data (mmu_output_data),
      .stall           (stall_w[g])
    );
  end

  assign inst_rdata_s = inst_rdata_w[sel];
  assign data_rdata_s = data_rdata_w[sel];
  assign inst_ready_s = inst_ready_w[sel];
  assign data_ready_s = data_ready_w[sel];
  assign rd_s         = rd_w[sel];
  assign wr_s         = wr_w[sel];
  assign addr_s       = addr_w[sel];
  assign wdata_s      = wdata_w[sel];
  assign byte_s       = byte_w[sel];
  assign stall_s      = stall_w[sel];

  // MMU contents; the store target returns a distinctive value so a wrong capture shows.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_rd = 32'h3C08_BFD0;
      32'h8000_0004: mem_rd = 32'h2402_0001;
      32'h8000_0010: mem_rd = 32'h1111_2222;
      32'h8040_0003: mem_rd = 32'h0000_00EE;
      default:       mem_rd = 32'h5555_5555;
    endcase
  endfunction

  assign mmu_output_data = mem_rd(addr_s);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic exp_bus(input logic rd, input logic wr, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int start, input int n);
    bus_t b;
    b.rd = rd; b.wr = wr; b.byt = byt; b.addr = addr; b.wdata = wdata;
    b.start = start; b.n = n;
    bq.push_back(b);
  endtask

  task automatic exp_rsp(input bit port, input logic [31:0] rdata, input int c);
    rsp_t r;
    r.port = port; r.rdata = rdata; r.cyc = c;
    rq.push_back(r);
  endtask

  // Advance to the start (+1) of cycle n; always terminates because cyc counts up.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: bus beats and ready pulses are checked against the scoreboard queues.
  always @(negedge clk) begin
    bus_t f;
    rsp_t r;
    if (rd_s | wr_s) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bus: rd %b wr %b addr %h required quiet", rd_s, wr_s, addr_s);
      end else begin
        f = bq[0];
        chk("bus_cycle", 32'(cyc), 32'(f.start + bidx));
        chk("bus_rd", 32'(rd_s), 32'(f.rd));
        chk("bus_wr", 32'(wr_s), 32'(f.wr));
        chk("bus_byte", 32'(byte_s), 32'(f.byt));
        chk("bus_addr", addr_s, f.addr);
        chk("bus_wdata", wdata_s, f.wdata);
        bidx++;
        if (bidx == f.n) begin
          void'(bq.pop_front());
          bidx = 0;
        end
      end
    end else begin
      chk("quiet_addr_wdata_byte", addr_s | wdata_s | 32'(byte_s), 32'd0);
    end
    if (inst_ready_s || data_ready_s) begin
      chk("ready_bus_quiet", 32'(rd_s | wr_s), 32'd0);
      chk("ready_not_both", 32'(inst_ready_s & data_ready_s), 32'd0);
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: inst %b data %b required none", inst_ready_s, data_ready_s);
      end else begin
        r = rq.pop_front();
        chk("rsp_port", 32'(data_ready_s), 32'(r.port));
        chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
        chk("rsp_rdata", data_ready_s ? data_rdata_s : inst_rdata_s, r.rdata);
      end
    end
  end

  task automatic data_access(input int w, input logic we, input logic byt,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata);
    int t0;
    t0 = cyc;
    exp_bus(~we, we, byt, addr, wdata, t0 + 1, 1 + w);
    exp_rsp(1'b1, exp_rdata, t0 + 2 + w);
    data_we = we; data_byte = byt; data_addr = addr; data_wdata = wdata;
    data_req = 1'b1;
    wait_cyc(t0 + 2 + w);
    data_req = 1'b0;
    wait_cyc(t0 + 3 + w);
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1; sel = 2'd0;
    inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_byte = 1'b0;
    inst_addr = 32'd0; data_addr = 32'd0; data_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state on every instance.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_inst_rdata", inst_rdata_s, 32'd0);
      chk("rst_data_rdata", data_rdata_s, 32'd0);
      chk("rst_inst_ready", 32'(inst_ready_s), 32'd0);
      chk("rst_data_ready", 32'(data_ready_s), 32'd0);
      chk("rst_rd_wr", 32'({rd_s, wr_s, byte_s}), 32'd0);
      chk("rst_addr", addr_s, 32'd0);
      chk("rst_wdata", wdata_s, 32'd0);
      chk("rst_stall", 32'(stall_s), 32'd0);
    end
    sel = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(cyc + 1);

    // W=0 fetch: bus in cycle 1, ready in cycle 2, stall high in cycles 0-1.
    t0 = cyc;
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0, t0 + 1, 1);
    exp_rsp(1'b0, 32'h3C08_BFD0, t0 + 2);
    inst_addr = 32'h8000_0000; inst_req = 1'b1;
    @(negedge clk); chk("t1_stall_c0", 32'(stall_s), 32'd1);
    @(negedge clk); chk("t1_stall_c1", 32'(stall_s), 32'd1);
    @(negedge clk); chk("t1_stall_c2", 32'(stall_s), 32'd0);
    wait_cyc(t0 + 3);
    inst_req = 1'b0;
    wait_cyc(t0 + 4);

    // W=2: byte store, then a load, then a word store that must not disturb data_rdata.
    sel = 2'd1;
    data_access(2, 1'b1, 1'b1, 32'h8040_0003, 32'h0000_00A5, 32'h0000_0000);
    data_access(2, 1'b0, 1'b0, 32'h8000_0010, 32'h0000_0000, 32'h1111_2222);
    data_access(2, 1'b1, 1'b0, 32'h8000_0020, 32'hCAFE_BABE, 32'h1111_2222);

    // Continuous contention from reset, W=0: data, inst, data, inst.
    sel = 2'd0;
    rst = 1'b1;
    inst_addr = 32'h8000_0000; data_addr = 32'h8000_0010;
    data_we = 1'b0; data_byte = 1'b0; data_wdata = 32'd0;
    inst_req = 1'b1; data_req = 1'b1;
    wait_cyc(cyc + 1);
    rst = 1'b0;
    t0 = cyc;
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0, t0 + 1, 1);
    exp_rsp(1'b1, 32'h1111_2222, t0 + 2);
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0, t0 + 3, 1);
    exp_rsp(1'b0, 32'h3C08_BFD0, t0 + 4);
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0, t0 + 5, 1);
    exp_rsp(1'b1, 32'h1111_2222, t0 + 6);
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0, t0 + 7, 1);
    exp_rsp(1'b0, 32'h3C08_BFD0, t0 + 8);
    wait_cyc(t0 + 8);
    inst_req = 1'b0; data_req = 1'b0;
    wait_cyc(t0 + 9);

    // data_req held through ready with a new address: re-grant one cycle later.
    t0 = cyc;
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'd0, t0 + 1, 1);
    exp_rsp(1'b1, 32'h2402_0001, t0 + 2);
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0, t0 + 4, 1);
    exp_rsp(1'b1, 32'h1111_2222, t0 + 5);
    data_addr = 32'h8000_0004; data_req = 1'b1;
    wait_cyc(t0 + 2);
    data_addr = 32'h8000_0010;
    @(negedge clk); chk("t4_stall_ready_cycle", 32'(stall_s), 32'd0);
    wait_cyc(t0 + 3);
    @(negedge clk); chk("t4_stall_pending", 32'(stall_s), 32'd1);
    wait_cyc(t0 + 5);
    data_req = 1'b0;
    wait_cyc(t0 + 6);

    // W=3 load interrupted by reset in cycle 2; then a tie goes to data.
    sel = 2'd2;
    t0 = cyc;
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0, t0 + 1, 2);
    data_addr = 32'h8000_0010; data_req = 1'b1;
    wait_cyc(t0 + 2);
    rst = 1'b1;
    wait_cyc(t0 + 3);
    rst = 1'b0; data_req = 1'b0;
    wait_cyc(t0 + 5);
    t1 = cyc;
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'd0, t1 + 1, 4);
    exp_rsp(1'b1, 32'h1111_2222, t1 + 5);
    exp_bus(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd0, t1 + 6, 4);
    exp_rsp(1'b0, 32'h3C08_BFD0, t1 + 10);
    inst_addr = 32'h8000_0000; inst_req = 1'b1; data_req = 1'b1;
    wait_cyc(t1 + 5);
    data_req = 1'b0;
    wait_cyc(t1 + 10);
    inst_req = 1'b0;
    wait_cyc(t1 + 12);

    chk("bus_queue_drained", 32'(bq.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single MMU memory port between the CPU's instruction-fetch requester and its load/store requester. It sequences each access onto the bus as a held multi-cycle transaction, latches read data, and returns a one-cycle ready pulse. It also drives the pipeline stall. It sits between the IF/MEM pipeline stages and the MMU, and is the only master of the MMU's `if_read`/`if_write`/`addr`/`input_data`/`bytemode` inputs.

## Interface
- `WAIT_CYCLES`, default 0: extra cycles each access is held on the bus beyond the first; range 0–15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req`  in  1  fetch request; held with `inst_addr` until `inst_ready`.
- `inst_addr`  in  32  fetch address (word access).
- `inst_rdata`  out  32  fetched word; valid while `inst_ready` is high.
- `inst_ready`  out  1  one-cycle completion pulse for a fetch.
- `data_req`  in  1  load/store request; held with its attributes until `data_ready`.
- `data_we`  in  1  1 = store, 0 = load.
- `data_byte`  in  1  byte access (LB/SB), passed to `mmu_bytemode`.
- `data_addr`  in  32  load/store address.
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load result; valid while `data_ready` is high.
- `data_ready`  out  1  one-cycle completion pulse for a load/store.
- `mmu_if_read`  out  1  MMU read strobe.
- `mmu_if_write`  out  1  MMU write strobe.
- `mmu_addr`  out  32  MMU address.
- `mmu_input_data`  out  32  MMU write data.
- `mmu_bytemode`  out  1  MMU byte mode.
- `mmu_output_data`  in  32  MMU read data.
- `stall`  out  1  pipeline stall: `(inst_req & ~inst_ready) | (data_req & ~data_ready)`.

## Operation
- States:
  - IDLE: bus quiet.
  - BUSY_D: data access on the bus.
  - BUSY_I: fetch on the bus.
- Register `last_grant`: 0 = inst, 1 = data.
- Bus outputs, `state`, `cnt`, `last_grant`, rdata registers and ready flags are all registered.
- Bus quiet means: `mmu_if_read`=`mmu_if_write`=`mmu_bytemode`=0, `mmu_addr`=0, `mmu_input_data`=0.
- Grant decision in IDLE, at the rising edge, using eligible requests only:
  - A port whose ready is high in the current cycle is ineligible; its request is treated as already consumed.
  - Only data eligible → BUSY_D.
  - Only inst eligible → BUSY_I.
  - Both eligible → grant the port not in `last_grant`. Reset value of `last_grant` is inst, so data wins the first tie.
  - On grant: update `last_grant`, load `cnt`=`WAIT_CYCLES`, and drive the bus from the granted port's inputs.
- BUSY_D bus values:
  - `mmu_if_read`=~`data_we`, `mmu_if_write`=`data_we`.
  - `mmu_addr`=`data_addr`, `mmu_input_data`=`data_wdata`, `mmu_bytemode`=`data_byte`.
- BUSY_I bus values: `mmu_if_read`=1, `mmu_if_write`=0, `mmu_addr`=`inst_addr`, `mmu_bytemode`=0, `mmu_input_data`=0.
- Bus values stay constant for the whole BUSY period.
- BUSY with `cnt`≠0: decrement `cnt`.
- BUSY with `cnt`=0, at the rising edge:
  - Return to IDLE and drive the bus quiet.
  - Set the granted port's ready for exactly one cycle.
  - Reads only: capture `mmu_output_data` into that port's rdata register. Stores leave `data_rdata` unchanged.
- rdata registers hold their value until the next read on the same port.
- Requests that change during BUSY are ignored; requesters must hold them stable.

## Timing
- Reset values: state IDLE, `cnt`=0, `last_grant`=inst, bus quiet, both ready flags 0, both rdata registers 0, `stall` follows its equation.
- Reset mid-access: the access is abandoned with no ready pulse and the bus goes quiet on the next cycle. An interrupted store may have partially completed; this is allowed.
- Latency, single request asserted in cycle 0:
  - Bus is driven in cycles 1 … 1+W.
  - Ready pulses in cycle 2+W.
  - With W=0: ready in cycle 2.
- Ready cycle: state is IDLE, and the other port may be granted at the end of it.
- Throughput: one access per 2+W cycles. Under continuous contention, grants strictly alternate.
- Ready never coincides with the bus being driven, so no back-to-back bus cycles occur. The MMU always sees a quiet cycle between transactions.
- Width rules: `cnt` is 4 bits. `WAIT_CYCLES`>15 is illegal (elaboration check).

## Test plan
- W=0, `inst_req`=1, `inst_addr`=0x80000000, MMU returns 0x3C08BFD0 → bus read in cycle 1; `inst_ready` in cycle 2 with `inst_rdata`=0x3C08BFD0; `stall`=1 in cycles 0–1 and 0 in cycle 2.
- W=2, store `data_we`=1, `data_byte`=1, `data_addr`=0x80400003, `data_wdata`=0xA5 → `mmu_if_write`=1 and `mmu_bytemode`=1 for cycles 1–3; `data_ready` in cycle 4; `data_rdata` unchanged.
- Both requests held continuously from reset, W=0 → grant order data, inst, data, inst; ready pulses alternate in cycles 2, 4, 6, 8.
- Requester keeps `data_req` high through its ready cycle with new address 0x80000010 → no re-grant in the ready cycle; the new access starts the cycle after.
- `rst` asserted in cycle 2 of a W=3 load → no `data_ready`; bus quiet from cycle 3; after release, a tie is granted to data.
